// File: rtl/ar_tag_allocator_if.sv
// ----------------------------------------------------------------------------
// ar_if : AR channel bundle shared by the tag allocator and its neighbours.
//
// Fields: valid, ready, id, addr, len, size, burst, qos.
// Modports:
//   sender   - drives valid and the payload fields, samples ready
//   receiver - samples valid and the payload fields, drives ready
// ----------------------------------------------------------------------------
interface ar_if #(
    parameter int ID_WIDTH    = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int LEN_WIDTH   = 8,
    parameter int SIZE_WIDTH  = 3,
    parameter int BURST_WIDTH = 2,
    parameter int QOS_WIDTH   = 4
);
    logic                   valid;
    logic                   ready;
    logic [ID_WIDTH-1:0]    id;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [LEN_WIDTH-1:0]   len;
    logic [SIZE_WIDTH-1:0]  size;
    logic [BURST_WIDTH-1:0] burst;
    logic [QOS_WIDTH-1:0]   qos;

    modport sender   (output valid, id, addr, len, size, burst, qos, input ready);
    modport receiver (input valid, id, addr, len, size, burst, qos, output ready);
endinterface

// File: rtl/ar_tag_allocator.sv
// ----------------------------------------------------------------------------
// ar_tag_allocator
//
// Sits in front of the outgoing AR FIFO. Every accepted AR is given the lowest
// free internal tag; the original ARID is remembered in a tag table and the AR
// is forwarded with its ID replaced by the zero-extended tag. The R path hands
// tags back through the release port and recovers the original ID through the
// combinational lookup port, which lets responses come back in tag order.
//
// Ports:
//   clk, rst    clock and asynchronous active-high reset
//   ar_in       AR from the ordering logic (ar_if.receiver)
//   ar_out      AR toward the request buffer, id = tag (ar_if.sender)
//   rel_valid   tag release strobe (last R beat of a burst)
//   rel_tag     tag being released
//   lkp_tag     tag to look up
//   lkp_id      original ARID stored for lkp_tag (combinational, 0 if out of range)
//   free_cnt    number of free tags (registered)
//   rel_err     sticky illegal-release flag
//
// Build option:
//   AR_TAG_REL_CHECK_EN - when defined, rel_err latches any release of a tag
//   that is already free or out of range, and an assertion reports it in
//   simulation. When undefined, rel_err is tied low and such releases are
//   silently ignored.
// ----------------------------------------------------------------------------
module ar_tag_allocator #(
    parameter int ID_WIDTH    = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int LEN_WIDTH   = 8,
    parameter int SIZE_WIDTH  = 3,
    parameter int BURST_WIDTH = 2,
    parameter int QOS_WIDTH   = 4,
    parameter int NUM_TAGS    = 16,
    localparam int TAG_W      = $clog2(NUM_TAGS),
    localparam int CNT_W      = $clog2(NUM_TAGS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    ar_if.receiver           ar_in,
    ar_if.sender             ar_out,
    input  logic             rel_valid,
    input  logic [TAG_W-1:0] rel_tag,
    input  logic [TAG_W-1:0] lkp_tag,
    output logic [ID_WIDTH-1:0] lkp_id,
    output logic [CNT_W-1:0] free_cnt,
    output logic             rel_err
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [NUM_TAGS-1:0]    free_q;
    logic [NUM_TAGS-1:0]    free_d;
    logic [ID_WIDTH-1:0]    id_tab_q [NUM_TAGS];
    logic [CNT_W-1:0]       free_cnt_q;
    logic [CNT_W-1:0]       free_cnt_d;

    logic                   out_valid_q;
    logic                   out_valid_d;
    logic [ID_WIDTH-1:0]    out_id_q;
    logic [ID_WIDTH-1:0]    out_id_d;
    logic [ADDR_WIDTH-1:0]  out_addr_q;
    logic [ADDR_WIDTH-1:0]  out_addr_d;
    logic [LEN_WIDTH-1:0]   out_len_q;
    logic [LEN_WIDTH-1:0]   out_len_d;
    logic [SIZE_WIDTH-1:0]  out_size_q;
    logic [SIZE_WIDTH-1:0]  out_size_d;
    logic [BURST_WIDTH-1:0] out_burst_q;
    logic [BURST_WIDTH-1:0] out_burst_d;
    logic [QOS_WIDTH-1:0]   out_qos_q;
    logic [QOS_WIDTH-1:0]   out_qos_d;

    // ------------------------------------------------------------------
    // Allocation / release decode
    // ------------------------------------------------------------------
    logic [TAG_W-1:0]    alloc_tag;
    logic                tag_avail;
    logic                in_ready;
    logic                accept;
    logic [NUM_TAGS-1:0] alloc_hit;   // one-hot of the entry written this cycle
    logic [NUM_TAGS-1:0] rel_hit;     // one-hot of rel_tag (all zero if out of range)
    logic [NUM_TAGS-1:0] rel_set;     // rel_hit restricted to tags actually in use
    logic [NUM_TAGS-1:0] lkp_hit;
    logic                rel_legal;

    // Fixed-priority encoder: scanning downward leaves the lowest free index.
    always_comb begin
        alloc_tag = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (free_q[i]) begin
                alloc_tag = TAG_W'(i);
            end
        end
    end

    assign tag_avail = |free_q;
    // Ready deliberately ignores ar_in.valid: it only reflects tag supply and
    // whether the single output slot can take a new entry this cycle.
    assign in_ready  = tag_avail & (~out_valid_q | ar_out.ready);
    assign accept    = ar_in.valid & in_ready;
    assign ar_in.ready = in_ready;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_TAGS; gi++) begin : g_tag
            assign alloc_hit[gi] = accept && (alloc_tag == TAG_W'(gi));
            assign rel_hit[gi]   = rel_valid && (rel_tag == TAG_W'(gi));
            assign lkp_hit[gi]   = (lkp_tag == TAG_W'(gi));

            // Entries are only rewritten on allocation; release leaves the
            // stale ID in place.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    id_tab_q[gi] <= '0;
                end else if (alloc_hit[gi]) begin
                    id_tab_q[gi] <= ar_in.id;
                end
            end
        end
    endgenerate

    // A release only counts if the tag is currently allocated. Releasing the
    // tag that is being allocated this cycle is impossible to make legal
    // because that tag is free, so rel_set and alloc_hit never overlap.
    assign rel_set   = rel_hit & ~free_q;
    assign rel_legal = |rel_set;

    assign free_d = (free_q & ~alloc_hit) | rel_set;

    always_comb begin
        free_cnt_d = free_cnt_q;
        case ({accept, rel_legal})
            2'b10:   free_cnt_d = free_cnt_q - CNT_W'(1);
            2'b01:   free_cnt_d = free_cnt_q + CNT_W'(1);
            default: free_cnt_d = free_cnt_q;
        endcase
    end

    // ------------------------------------------------------------------
    // One-entry output register
    // ------------------------------------------------------------------
    always_comb begin
        out_valid_d = out_valid_q;
        out_id_d    = out_id_q;
        out_addr_d  = out_addr_q;
        out_len_d   = out_len_q;
        out_size_d  = out_size_q;
        out_burst_d = out_burst_q;
        out_qos_d   = out_qos_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_id_d    = ID_WIDTH'(alloc_tag);
            out_addr_d  = ar_in.addr;
            out_len_d   = ar_in.len;
            out_size_d  = ar_in.size;
            out_burst_d = ar_in.burst;
            out_qos_d   = ar_in.qos;
        end else if (out_valid_q && ar_out.ready) begin
            // Drained with nothing behind it: zero the fields so the bus is
            // quiet while idle.
            out_valid_d = 1'b0;
            out_id_d    = '0;
            out_addr_d  = '0;
            out_len_d   = '0;
            out_size_d  = '0;
            out_burst_d = '0;
            out_qos_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            free_q      <= '1;
            free_cnt_q  <= CNT_W'(NUM_TAGS);
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
            out_addr_q  <= '0;
            out_len_q   <= '0;
            out_size_q  <= '0;
            out_burst_q <= '0;
            out_qos_q   <= '0;
        end else begin
            free_q      <= free_d;
            free_cnt_q  <= free_cnt_d;
            out_valid_q <= out_valid_d;
            out_id_q    <= out_id_d;
            out_addr_q  <= out_addr_d;
            out_len_q   <= out_len_d;
            out_size_q  <= out_size_d;
            out_burst_q <= out_burst_d;
            out_qos_q   <= out_qos_d;
        end
    end

    assign ar_out.valid = out_valid_q;
    assign ar_out.id    = out_id_q;
    assign ar_out.addr  = out_addr_q;
    assign ar_out.len   = out_len_q;
    assign ar_out.size  = out_size_q;
    assign ar_out.burst = out_burst_q;
    assign ar_out.qos   = out_qos_q;
    assign free_cnt     = free_cnt_q;

    // ------------------------------------------------------------------
    // Lookup: one-hot OR mux, so an out-of-range tag reads back zero.
    // ------------------------------------------------------------------
    always_comb begin
        lkp_id = '0;
        for (int i = 0; i < NUM_TAGS; i++) begin
            if (lkp_hit[i]) begin
                lkp_id = lkp_id | id_tab_q[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Illegal-release detection
    // ------------------------------------------------------------------
`ifdef AR_TAG_REL_CHECK_EN
    logic rel_err_q;
    logic rel_err_d;

    assign rel_err_d = rel_err_q | (rel_valid & ~rel_legal);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rel_err_q <= 1'b0;
        end else begin
            rel_err_q <= rel_err_d;
        end
    end

    assign rel_err = rel_err_q;

    a_rel_legal: assert property (@(posedge clk) disable iff (rst) rel_valid |-> rel_legal)
        else $error("release of a free or out-of-range tag");
`else
    assign rel_err = 1'b0;
`endif

endmodule

// File: tb/tb_ar_tag_allocator.sv
// ----------------------------------------------------------------------------
// tb_ar_tag_allocator
//
// Directed scenarios followed by a randomized run. A reference model tracks
// the set of free tags, the remembered IDs and the expected output slot; the
// DUT is compared against it every cycle on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_ar_tag_allocator;

    localparam int N = 16;

    logic clk;
    logic rst;
    logic rel_valid;
    logic [3:0] rel_tag;
    logic [3:0] lkp_tag;
    logic [31:0] lkp_id;
    logic [4:0] free_cnt;
    logic rel_err;

    ar_if ar_in_if ();
    ar_if ar_out_if ();

    ar_tag_allocator dut (
        .clk       (clk),
        .rst       (rst),
        .ar_in     (ar_in_if),
        .ar_out    (ar_out_if),
        .rel_valid (rel_valid),
        .rel_tag   (rel_tag),
        .lkp_tag   (lkp_tag),
        .lkp_id    (lkp_id),
        .free_cnt  (free_cnt),
        .rel_err   (rel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model
    bit          m_free [N];
    logic [31:0] m_id   [N];
    bit          m_ov;
    logic [31:0] m_oid;
    logic [31:0] m_oaddr;
    logic [7:0]  m_olen;
    logic [2:0]  m_osize;
    logic [1:0]  m_oburst;
    logic [3:0]  m_oqos;
    bit          m_err;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int model_free_count();
        int c = 0;
        for (int i = 0; i < N; i++) if (m_free[i]) c++;
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_free[i] = 1'b1;
            m_id[i]   = '0;
        end
        m_ov = 0; m_oid = '0; m_oaddr = '0; m_olen = '0;
        m_osize = '0; m_oburst = '0; m_oqos = '0; m_err = 0;
    endtask

    task automatic idle_inputs();
        ar_in_if.valid = 0; ar_in_if.id = '0; ar_in_if.addr = '0;
        ar_in_if.len = '0; ar_in_if.size = '0; ar_in_if.burst = '0; ar_in_if.qos = '0;
        ar_out_if.ready = 0; rel_valid = 0; rel_tag = '0; lkp_tag = '0;
    endtask

    // Asserted one time unit after a rising edge; checks that reset acts at
    // once, without waiting for a clock.
    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        #1;
        check("rst_out_valid", ar_out_if.valid, 0);
        check("rst_free_cnt", free_cnt, N);
        check("rst_rel_err", rel_err, 0);
        check("rst_out_id", ar_out_if.id, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // One clock cycle: drive inputs, compare everything at the falling edge,
    // advance the model by the allocation/release rules, step past the edge.
    task automatic step(input bit v, input logic [31:0] id, input logic [31:0] addr,
                        input bit ordy, input bit rv, input logic [3:0] rt,
                        input logic [3:0] lt);
        bit   avail;
        bit   exp_rdy;
        bit   acc;
        bit   legal;
        int   t;
        ar_in_if.valid = v;
        ar_in_if.id    = id;
        ar_in_if.addr  = addr;
        ar_in_if.len   = 8'($urandom);
        ar_in_if.size  = 3'($urandom);
        ar_in_if.burst = 2'($urandom);
        ar_in_if.qos   = 4'($urandom);
        ar_out_if.ready = ordy;
        rel_valid = rv;
        rel_tag   = rt;
        lkp_tag   = lt;
        @(negedge clk);

        avail   = model_free_count() > 0;
        exp_rdy = avail && (!m_ov || ordy);
        check("in_ready",  ar_in_if.ready, exp_rdy);
        check("out_valid", ar_out_if.valid, m_ov);
        check("out_id",    ar_out_if.id, m_oid);
        check("out_addr",  ar_out_if.addr, m_oaddr);
        check("out_len",   ar_out_if.len, m_olen);
        check("out_size",  ar_out_if.size, m_osize);
        check("out_burst", ar_out_if.burst, m_oburst);
        check("out_qos",   ar_out_if.qos, m_oqos);
        check("free_cnt",  free_cnt, model_free_count());
        check("rel_err",   rel_err, m_err);
        check("lkp_id",    lkp_id, m_id[lt]);

        acc = v && exp_rdy;
        t = -1;
        for (int i = N - 1; i >= 0; i--) if (m_free[i]) t = i;
        legal = rv && !m_free[rt];
        if (acc) begin
            m_id[t]   = id;
            m_free[t] = 1'b0;
            m_ov      = 1;
            m_oid     = t;
            m_oaddr   = addr;
            m_olen    = ar_in_if.len;
            m_osize   = ar_in_if.size;
            m_oburst  = ar_in_if.burst;
            m_oqos    = ar_in_if.qos;
        end else if (m_ov && ordy) begin
            m_ov = 0; m_oid = '0; m_oaddr = '0; m_olen = '0;
            m_osize = '0; m_oburst = '0; m_oqos = '0;
        end
        if (legal) m_free[rt] = 1'b1;
`ifdef AR_TAG_REL_CHECK_EN
        else if (rv) m_err = 1;
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pick;
        logic [3:0] rt;
        rst = 1'b1;
        idle_inputs();
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Single AR
        step(1, 32'hA5, 32'h1000, 1, 0, 0, 0);
        check("s1_id", ar_out_if.id, 0);
        check("s1_addr", ar_out_if.addr, 32'h1000);
        check("s1_free", free_cnt, 15);
        check("s1_lkp", lkp_id, 32'hA5);
        $display("single AR: tag %0d addr 0x%0h", ar_out_if.id, ar_out_if.addr);

        // Fill every tag back to back
        do_reset();
        for (int i = 0; i < N; i++) begin
            step(1, 32'h100 + i, $urandom, 1, 0, 0, 4'(i));
            check("s2_tag", ar_out_if.id, i);
        end
        check("s2_ready", ar_in_if.ready, 0);
        check("s2_free", free_cnt, 0);
        $display("fill: %0d tags allocated, free_cnt %0d", N, free_cnt);
        step(1, 32'h1FF, $urandom, 1, 0, 0, 4'd15);

        // Release tag 5 from full, then reuse it
        step(0, 0, 0, 1, 1, 4'd5, 0);
        check("s3_ready", ar_in_if.ready, 1);
        step(1, 32'h200, $urandom, 1, 0, 0, 4'd5);
        check("s3_tag", ar_out_if.id, 5);
        check("s3_lkp", lkp_id, 32'h200);
        $display("reuse: id 0x200 -> tag %0d", ar_out_if.id);

        // Backpressure with two ARs presented
        do_reset();
        step(1, 32'h11, 32'hA000, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 32'h22, 32'hB000, 0, 0, 0, 0);
            check("s4_hold_addr", ar_out_if.addr, 32'hA000);
        end
        step(1, 32'h22, 32'hB000, 1, 0, 0, 0);
        check("s4_second_tag", ar_out_if.id, 1);
        check("s4_second_addr", ar_out_if.addr, 32'hB000);
        step(0, 0, 0, 1, 0, 0, 4'd1);
        $display("backpressure: second AR tag 1 after stall");

        // Simultaneous accept + legal release, then illegal release
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 32'h300 + i, $urandom, 1, 0, 0, 0);
        step(1, 32'h304, $urandom, 1, 1, 4'd3, 0);
        check("s5_cnt", free_cnt, 12);
        step(1, 32'h305, $urandom, 1, 0, 0, 4'd3);
        check("s5_tag3", ar_out_if.id, 3);
        step(0, 0, 0, 1, 1, 4'd7, 0);
        check("s5_cnt_ill", free_cnt, 11);
`ifdef AR_TAG_REL_CHECK_EN
        check("s5_rel_err", rel_err, 1);
`else
        check("s5_rel_err", rel_err, 0);
`endif
        $display("accept+release: free_cnt %0d rel_err %0d", free_cnt, rel_err);

        // Reset with tags in use and the output occupied
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 32'h400 + i, $urandom, 1, 0, 0, 0);
        check("s6_pre_valid", ar_out_if.valid, 1);
        do_reset();
        step(1, 32'h500, $urandom, 1, 0, 0, 0);
        check("s6_tag0", ar_out_if.id, 0);
        $display("mid-run reset: next AR tag %0d", ar_out_if.id);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end
            pick = int'($urandom_range(0, 9));
            rt = 4'($urandom);
            if (pick != 0) begin
                for (int k = 0; k < N; k++) begin
                    if (!m_free[(int'(rt) + k) % N]) begin
                        rt = 4'((int'(rt) + k) % N);
                        break;
                    end
                end
            end
            step($urandom_range(0, 3) != 0, $urandom, $urandom,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0,
                 rt, 4'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/ar_tag_allocator.md
Name: ar_tag_allocator

Overview:
- Upstream neighbour of the outgoing AR FIFO. Accepts AR requests from the ordering logic, allocates a free internal tag per request, and records the original ARID in a tag table.
- Forwards each AR downstream with ARID replaced by the zero-extended tag.
- The R-return path releases tags and reads back the original ID through a lookup port. This enables response reordering by tag.

Parameters:
- ID_WIDTH, 32, width of ARID on both sides; must be >= TAG_W.
- ADDR_WIDTH, 32, ARADDR width.
- LEN_WIDTH, 8, ARLEN width.
- SIZE_WIDTH, 3, ARSIZE width.
- BURST_WIDTH, 2, ARBURST width.
- QOS_WIDTH, 4, ARQOS width.
- NUM_TAGS, 16, number of outstanding tags; range 2..64. Derived localparams: TAG_W = $clog2(NUM_TAGS), CNT_W = $clog2(NUM_TAGS+1).

Ports:
- clk  input  1  clock; single clock domain.
- rst  input  1  asynchronous reset, active-high.
- ar_in  ar_if.receiver  bundle  AR from ordering logic; fields valid/ready/id/addr/len/size/burst/qos.
- ar_out  ar_if.sender  bundle  AR toward the outgoing request buffer; id carries the tag.
- rel_valid  input  1  release strobe from the R path; asserted on the last beat of a burst.
- rel_tag  input  TAG_W  tag being released.
- lkp_tag  input  TAG_W  tag to look up.
- lkp_id  output  ID_WIDTH  original ARID stored for lkp_tag; combinational.
- free_cnt  output  CNT_W  number of free tags; registered.
- rel_err  output  1  sticky illegal-release flag; see Optional Feature.

Behaviour:
- State:
  - free_q[NUM_TAGS] bitmap; 1 = free.
  - id_tab[NUM_TAGS] of ID_WIDTH.
  - One-entry output register (out_valid_q plus AR fields).
  - free_cnt_q.
- Reset (async, any time, including mid-burst):
  - free_q all ones; id_tab zeroed; out_valid_q=0.
  - ar_out fields 0; free_cnt=NUM_TAGS; rel_err=0.
  - Any in-flight output entry is dropped.
- Allocation: alloc_tag = lowest-index set bit of free_q (fixed priority encoder). tag_avail = |free_q.
- ar_in.ready = tag_avail & (~out_valid_q | ar_out.ready). It is combinational and never depends on ar_in.valid.
- accept = ar_in.valid & ar_in.ready. On accept:
  - id_tab[alloc_tag] <= ar_in.id.
  - free_q[alloc_tag] <= 0.
  - Output register loads addr/len/size/burst/qos unchanged, id = zero-extended alloc_tag, out_valid_q <= 1.
- Latency: exactly 1 cycle from accept to ar_out.valid. Full throughput of 1 AR/cycle while tags remain and downstream is ready.
- ar_out.valid = out_valid_q. The output holds stable while valid & ~ready.
- On ar_out.valid & ar_out.ready with no accept: out_valid_q <= 0 and fields zeroed.
- Release:
  - On rel_valid with free_q[rel_tag]==0: free_q[rel_tag] <= 1.
  - The tag becomes allocatable the next cycle. There is no same-cycle bypass.
  - id_tab entries are not cleared on release.
- Illegal release (tag already free, or rel_tag >= NUM_TAGS) has no state change.
- Simultaneous accept and release:
  - Both take effect.
  - free_cnt_q unchanged if the release is legal; otherwise it decrements.
  - If rel_tag == alloc_tag it cannot be legal, since the tag is already free.
- free_cnt_q: +1 on legal release only; -1 on accept only; unchanged on both or neither. It never exceeds NUM_TAGS and never underflows; the ready gating guarantees this.
- Exhaustion: with free_cnt=0, ar_in.ready=0 until the cycle after a legal release.
- lkp_id = id_tab[lkp_tag], purely combinational. An out-of-range lkp_tag returns 0.

Optional Feature:
- Macro AR_TAG_REL_CHECK_EN.
- Defined:
  - rel_err is set on any illegal release and stays set until rst.
  - An SVA assertion flags the same condition in simulation.
- Undefined:
  - rel_err is tied to 0.
  - Illegal releases are silently ignored.
  - No assertion logic is compiled.

Test Plan:
- Reset then single AR (id=0xA5, addr=0x1000, ar_out.ready=1) -> ar_out.valid the next cycle with id=0, addr=0x1000; free_cnt=15; lkp_tag=0 gives lkp_id=0xA5.
- 16 back-to-back ARs, ids 0x100..0x10F, ready held 1 -> tags 0..15 in order; ar_in.ready=0 after the 16th accept; free_cnt=0.
- From the full state, release tag 5 -> ar_in.ready=1 in the following cycle; next AR id=0x200 gets tag 5; lkp_tag=5 gives 0x200.
- ar_out.ready=0 for 3 cycles with 2 ARs presented -> first AR held stable on ar_out; ar_in.ready=0 while the output register is occupied; second AR accepted on the ready cycle with no loss.
- Same-cycle accept and legal release of tag 3 -> free_cnt unchanged; tag 3 free next cycle. Release of already-free tag 7 -> free_cnt unchanged; rel_err=1 with AR_TAG_REL_CHECK_EN defined, 0 without.
- Assert rst while 4 tags are in use and ar_out.valid=1 -> immediately ar_out.valid=0 and free_cnt=16; next AR receives tag 0.
